// File: rtl/fp_div_if.sv
// Start/operand/result handshake bundle for the single-precision divider.
interface fp_div_if;
   logic        start;
   logic [31:0] X;
   logic [31:0] Y;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (output start, X, Y, input busy, done, result);
   modport slave  (input start, X, Y, output busy, done, result);
endinterface

// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 single-precision divider: restoring mantissa division,
// truncating rounding, denormal inputs flushed to zero.
module fp_div (
   input  logic     clk,
   input  logic     reset,
   fp_div_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

   state_t             state;
   logic               sign;
   logic [23:0]        m_y;
   logic [24:0]        rem;
   logic [24:0]        quo;
   logic [4:0]         cnt;
   logic signed [9:0]  exp_diff;
   logic               pend;
   logic [31:0]        pend_res;

   logic               x_zero;
   logic               y_zero;
   logic               rem_ge;
   logic [24:0]        rem_sub;
   logic signed [9:0]  norm_exp;
   logic [22:0]        norm_mant;

   function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                            input logic [22:0] m);
      if (e >= 10'sd255)    return {s, 8'hFF, 23'd0};
      else if (e <= 10'sd0) return {s, 31'd0};
      else                  return {s, e[7:0], m};
   endfunction

   function automatic logic [31:0] special_res(input logic s, input logic xz, input logic yz);
      if (xz && yz) return 32'h7FC0_0000;
      else if (xz)  return {s, 31'd0};
      else          return {s, 8'hFF, 23'd0};
   endfunction

   always_comb begin
      x_zero  = (bus.X[30:23] == 8'd0);
      y_zero  = (bus.Y[30:23] == 8'd0);
      rem_ge  = (rem >= {1'b0, m_y});
      rem_sub = rem - {1'b0, m_y};
      // q[24] is the integer bit; when clear the quotient lies in [0.5,1)
      if (quo[24]) begin
         norm_exp  = exp_diff + 10'sd127;
         norm_mant = quo[23:1];
      end else begin
         norm_exp  = exp_diff + 10'sd126;
         norm_mant = quo[22:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= 32'd0;
         sign       <= 1'b0;
         m_y        <= 24'd0;
         rem        <= 25'd0;
         quo        <= 25'd0;
         cnt        <= 5'd0;
         exp_diff   <= 10'sd0;
         pend       <= 1'b0;
         pend_res   <= 32'd0;
      end else begin
         bus.done <= 1'b0;
         pend     <= 1'b0;
         // Special operands finish one edge after acceptance without leaving IDLE
         if (pend) begin
            bus.done   <= 1'b1;
            bus.result <= pend_res;
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sign <= bus.X[31] ^ bus.Y[31];
                  if (x_zero || y_zero) begin
                     pend     <= 1'b1;
                     pend_res <= special_res(bus.X[31] ^ bus.Y[31], x_zero, y_zero);
                  end else begin
                     state    <= CALC;
                     bus.busy <= 1'b1;
                     m_y      <= {1'b1, bus.Y[22:0]};
                     rem      <= {2'b01, bus.X[22:0]};
                     quo      <= 25'd0;
                     cnt      <= 5'd24;
                     exp_diff <= $signed({2'b00, bus.X[30:23]}) - $signed({2'b00, bus.Y[30:23]});
                  end
               end
            end
            CALC: begin
               quo[cnt] <= rem_ge;
               rem      <= rem_ge ? (rem_sub << 1) : (rem << 1);
               cnt      <= cnt - 5'd1;
               if (cnt == 5'd0) state <= NORM;
            end
            NORM: begin
               bus.result <= pack_sat(sign, norm_exp, norm_mant);
               bus.done   <= 1'b1;
               bus.busy   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: expected quotient and done edge queued at acceptance.
module tb_fp_div;
   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   fp_div_if bus();

   fp_div dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", bus.result, 32'hxxxx_xxxx);
         end else begin
            mon_e = sb.pop_front();
            chk("result", bus.result, mon_e.res);
            chk("latency_edge", cyc, mon_e.cyc);
         end
      end
   end

   task automatic wait_done(output int nbusy);
      int n;
      n = 0;
      nbusy = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         if (bus.busy === 1'b1) nbusy++;
         @(negedge clk);
         n++;
      end
      chk("done_seen", bus.done, 1'b1);
   endtask

   task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] res,
                     input int lat);
      int nbusy;
      bus.X = x;
      bus.Y = y;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      sb.push_back('{res, cyc + lat});
      wait_done(nbusy);
      chk("busy_cycles", nbusy, (lat == 26) ? 32'd26 : 32'd0);
      chk("busy_at_done", bus.busy, 1'b0);
   endtask

   initial begin
      int nb;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.X = 32'd0;
      bus.Y = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_result", bus.result, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);
      op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);
      repeat (3) @(negedge clk);
      chk("result_hold", bus.result, 32'h3EAA_AAAA);
      op(32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, 26);
      op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1);
      op(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1);
      op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);
      op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 26);
      op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 26);
      repeat (2) @(negedge clk);

      // Start ignored while busy, then a start in the done cycle is accepted
      bus.X = 32'h40C0_0000;
      bus.Y = 32'h4000_0000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      sb.push_back('{32'h4040_0000, cyc + 26});
      repeat (8) @(negedge clk);
      bus.X = 32'h3F80_0000;
      bus.Y = 32'h4000_0000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(nb);
      op(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 26);
      repeat (2) @(negedge clk);

      // Reset mid-CALC aborts without a done pulse
      bus.X = 32'h40C0_0000;
      bus.Y = 32'h4000_0000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_result", bus.result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_idle_result", bus.result, 32'd0);
      op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);
      repeat (3) @(negedge clk);

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-003 start  input  1  request strobe; sampled only in IDLE.
REQ-004 X  input  32  IEEE-754 single dividend; captured on the accepting edge.
REQ-005 Y  input  32  IEEE-754 single divisor; captured on the accepting edge.
REQ-006 busy  output  1  high while an accepted operation is in flight (CALC or NORM).
REQ-007 done  output  1  one-cycle pulse; result is valid on that cycle.
REQ-008 result  output  32  quotient X/Y; held stable from the done cycle until the next accepted start.

Function
REQ-009 States SHALL be IDLE, CALC and NORM; the reset state is IDLE.
REQ-010 In IDLE with start=1, the block SHALL capture X and Y, compute sign = X[31]^Y[31], and classify the operands.
REQ-011 An operand SHALL be zero when its exponent field is 0; denormals are treated as zero, and exponent 0xFF is treated as an ordinary exponent (no NaN/Inf inputs).
REQ-012 Special cases SHALL bypass CALC: from the accepting edge the block returns to IDLE, and done plus result are registered on the next edge (latency 1).
- X zero, Y nonzero: result = {sign, 31'b0}.
- Y zero, X nonzero: result = {sign, 8'hFF, 23'b0}.
- Both zero: result = 32'h7FC00000.
REQ-013 Normal case: operands go to CALC with mX = {1,X[22:0]}, mY = {1,Y[22:0]}, remainder R = mX (25 bits), iteration counter = 24, and exponent diff E = X[30:23] - Y[30:23], held as a 10-bit signed value.
REQ-014 Each CALC cycle SHALL perform one restoring step:
- if R >= mY: q[cnt] = 1, R = (R - mY) << 1;
- else: q[cnt] = 0, R = R << 1;
- cnt decrements by 1.
REQ-015 CALC SHALL last exactly 25 cycles (cnt 24 down to 0), producing the 25-bit quotient q with q[24] as the integer bit; then state goes to NORM.
REQ-016 NORM SHALL normalise:
- if q[24] = 1: mantissa = q[23:1], exponent = E + 127;
- else: mantissa = q[22:0], exponent = E + 126.
- Rounding is truncation.
REQ-017 In NORM, an exponent >= 255 SHALL give {sign, 8'hFF, 23'b0}, an exponent <= 0 SHALL give {sign, 31'b0}, and any other exponent SHALL give {sign, exponent[7:0], mantissa}.
REQ-018 NORM SHALL register the result, pulse done for one cycle, and return to IDLE.
REQ-019 Normal latency SHALL be 26 rising edges from the accepting edge to the edge that asserts done.
REQ-020 start SHALL be ignored while busy=1; neither the operands nor the counter change.
REQ-021 start high in the done cycle SHALL be accepted, because the state is IDLE again; back-to-back operations therefore have no idle gap.
REQ-022 busy SHALL deassert on the same edge that asserts done.

Reset
REQ-023 On reset assertion:
- state = IDLE, busy = 0, done = 0, result = 32'h00000000;
- counter, remainder and quotient are cleared.
REQ-024 Reset asserted mid-CALC or mid-NORM SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-025 X=0x40C00000 (6.0), Y=0x40000000 (2.0), start 1 cycle -> done exactly 26 edges later, result=0x40400000; busy high for the 26 intervening cycles.
REQ-026 X=0x3F800000, Y=0x40400000 (1/3) -> result=0x3EAAAAAA (truncated); X=0xBFC00000, Y=0x3F000000 -> result=0xC0400000.
REQ-027 Special cases, each with done 1 edge after start:
- X=0x3F800000, Y=0x00000000 -> 0x7F800000;
- X=0x00000000, Y=0xC0000000 -> 0x80000000;
- X=Y=0x00000000 -> 0x7FC00000.
REQ-028 Exponent limits:
- X=0x7F000000, Y=0x00800000 -> 0x7F800000 (overflow);
- X=0x00800000, Y=0x7F000000 -> 0x00000000 (underflow).
REQ-029 Handshake:
- start 6.0/2.0, then at cycle 10 pulse start with X=0x3F800000, Y=0x40000000 -> ignored; single done with 0x40400000;
- then start in the done cycle -> accepted, next result 0x3F000000.
REQ-030 Start an operation, assert reset at cycle 12 for 2 cycles -> no done, outputs zero; restart 6.0/2.0 -> correct result after 26 edges.
